// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, decode valid/ready and branch redirect.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if;
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [ILEN-1:0] imem_data;
    logic            instr_valid;
    logic [ILEN-1:0] instruction;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            branch_taken;
    logic [XLEN-1:0] branch_pc;
    logic [XLEN-1:0] branch_offset;

    modport master (
        output imem_req, imem_addr, instr_valid, instruction, instr_pc,
        input  imem_ack, imem_data, instr_ready, branch_taken, branch_pc, branch_offset
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instruction, instr_pc,
        output imem_ack, imem_data, instr_ready, branch_taken, branch_pc, branch_offset
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over req/ack, buffers one
// instruction toward decode and redirects on resolved branches.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic         clk,
    input  logic         reset_n,
    fetch_unit_if.master bus
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            valid_q, valid_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] target_c;

    // Redirect target is word aligned; sum wraps modulo 2^64.
    assign target_c = (bus.branch_pc + bus.branch_offset) & ~XLEN'(3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (bus.branch_taken) state_d = bus.imem_ack ? FETCH : DROP;
                else if (bus.imem_ack) state_d = HOLD;
            end
            HOLD:  if (bus.branch_taken || bus.instr_ready) state_d = FETCH;
            DROP:  if (bus.imem_ack) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; a redirect always outranks a decode handshake.
    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                if (bus.branch_taken) begin
                    pc_d       = target_c;
                    req_addr_d = target_c;
                end else begin
                    req_addr_d = pc_q;
                end
            end
            FETCH: begin
                if (bus.branch_taken) begin
                    pc_d = target_c;
                    if (bus.imem_ack) req_addr_d = target_c;
                end else if (bus.imem_ack) begin
                    instr_d    = bus.imem_data;
                    instr_pc_d = req_addr_q;
                    valid_d    = 1'b1;
                    pc_d       = req_addr_q + XLEN'(4);
                end
            end
            HOLD: begin
                if (bus.branch_taken) begin
                    valid_d    = 1'b0;
                    pc_d       = target_c;
                    req_addr_d = target_c;
                end else if (bus.instr_ready) begin
                    valid_d    = 1'b0;
                    req_addr_d = pc_q;
                end
            end
            DROP: begin
                if (bus.branch_taken) pc_d = target_c;
                if (bus.imem_ack) req_addr_d = bus.branch_taken ? target_c : pc_q;
            end
            default: ;
        endcase
    end

    assign req_d = (state_d == FETCH) || (state_d == DROP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = req_addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instruction = instr_q;
    assign bus.instr_pc    = instr_pc_q;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the immediate sign extender and decoder. It keeps the program counter and issues word fetches to instruction memory over a req/ack handshake. It buffers one fetched instruction toward decode over a valid/ready handshake. It redirects the PC using the 64-bit branch offset that the sign extender produces from the CB/B-format immediate, which is already shifted left by 2.

## Interface
- RESET_PC, 64'h0: PC value loaded on reset; bits [1:0] must be 0.
- CLK  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- ImemReq  out  1  fetch request to instruction memory.
- ImemAddr  out  64  fetch address; stable while ImemReq=1 and ImemAck=0.
- ImemAck  in  1  memory response; ImemData is valid in the same cycle.
- ImemData  in  32  fetched instruction word.
- InstrValid  out  1  Instruction and InstrPC hold a live instruction.
- Instruction  out  32  buffered instruction; bits [25:0] feed the sign extender.
- InstrPC  out  64  address of the buffered instruction.
- InstrReady  in  1  decode accepts the instruction on an edge where InstrValid=1 and InstrReady=1.
- BranchTaken  in  1  single-cycle redirect strobe from the branch resolver.
- BranchPC  in  64  PC of the resolving branch.
- BranchOffset  in  64  sign-extended, pre-shifted offset.

## Operation
- Registers:
  - PC: next address to fetch.
  - ReqAddr: address of the outstanding request.
  - Instruction buffer: one entry.
  - State: IDLE, FETCH, HOLD, DROP.
- ImemReq = (state==FETCH or DROP). ImemAddr = ReqAddr.
- Redirect target = BranchPC + BranchOffset, computed modulo 2^64, with bits [1:0] forced to 0. Sequential increment is PC + 4, also modulo 2^64, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- IDLE (reset state): on the first edge after Reset_n deasserts, ReqAddr <= PC and the state moves to FETCH.
- FETCH, no BranchTaken:
  - On ImemAck: Instruction <= ImemData, InstrPC <= ReqAddr, InstrValid <= 1, PC <= ReqAddr + 4, state moves to HOLD.
  - Otherwise: hold.
- FETCH with BranchTaken:
  - If ImemAck is also high: discard ImemData, PC <= target, ReqAddr <= target, stay in FETCH.
  - Otherwise: PC <= target, state moves to DROP. ReqAddr is unchanged because the request must complete.
- HOLD, no BranchTaken:
  - On InstrReady: InstrValid <= 0, ReqAddr <= PC, state moves to FETCH.
  - Otherwise: all outputs hold.
- HOLD with BranchTaken: this has priority over InstrReady. InstrValid <= 0, PC <= target, ReqAddr <= target, state moves to FETCH. The buffered instruction is squashed even if InstrReady is high.
- DROP: ImemReq stays high with the old ReqAddr.
  - On ImemAck: discard the data, ReqAddr <= PC, state moves to FETCH.
  - A further BranchTaken in DROP overwrites PC with the new target; the latest redirect wins. If ImemAck and BranchTaken occur in the same cycle, the new target is fetched next.
- BranchTaken in IDLE: PC <= target, and the first fetch uses the target.
- Unreachable state encodings go to IDLE.

## Timing
- Reset (async assert, release synchronised by the environment):
  - ImemReq=0, ImemAddr=RESET_PC, PC=RESET_PC.
  - InstrValid=0, Instruction=0, InstrPC=0, state=IDLE.
- First ImemReq is high in the cycle after the first post-reset edge.
- Instruction latency: InstrValid rises on the edge that samples ImemAck=1.
- Throughput: with a zero-wait memory (ack in the request cycle) and InstrReady held at 1, one instruction is delivered every 2 cycles.
- Redirect penalty:
  - From HOLD: ImemReq for the target is high in the cycle after BranchTaken.
  - From FETCH without ack: the target request starts in the cycle after the pending ack.
- Reset mid-operation: all registers return to their reset values immediately. Any outstanding memory request is abandoned, and memory must tolerate this.

## Test plan
- Reset release, zero-wait memory returning 32'hAAAA_0000 + addr, InstrReady=1 -> ImemAddr sequence 0,4,8,12; Instruction/InstrPC match per address; InstrValid high every other cycle.
- Memory acks after 3 wait cycles -> ImemAddr stable at 0x8 for 4 cycles with ImemReq=1; one instruction delivered with InstrPC=0x8.
- InstrReady=0 for 5 cycles while in HOLD -> Instruction, InstrPC, InstrValid=1 stable; ImemReq=0; fetch of next PC starts the cycle after InstrReady=1.
- BranchTaken in HOLD, BranchPC=0x100, BranchOffset=64'hFFFF_FFFF_FFFF_FFF0 -> InstrValid drops, next ImemAddr=0xF0, buffered instruction never accepted.
- BranchTaken while request at 0x20 is waiting for ack (target 0x400), then a second BranchTaken (target 0x800) before ack -> ack at 0x20 discarded; next ImemAddr=0x800.
- PC=64'hFFFF_FFFF_FFFF_FFFC fetched, then Reset_n pulsed low mid-request with RESET_PC=0x1000 -> sequential wrap to 0; on reset all outputs take reset values at once, and the first fetch after release is 0x1000.
